// File: rtl/control_sequencer.sv
`default_nettype none
// ============================================================================
// control_sequencer : fetch/execute control FSM with Moore strobe decode
// Rev 1.0
// ============================================================================
module control_sequencer (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] instruction,
  input  logic        mem_done,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic        PCout,
  output logic        PCin,
  output logic        IncPC,
  output logic        MARin,
  output logic        MDRin,
  output logic        MDRout,
  output logic        IRin,
  output logic        Yin,
  output logic        Zin,
  output logic        Zlowout,
  output logic        Cout,
  output logic        Read,
  output logic        Write,
  output logic [4:0]  alu_op,
  output logic        run,
  output logic        illegal_op
);

  typedef enum logic [3:0] {
    ST_RST  = 4'd0,
    ST_T0   = 4'd1,
    ST_T1   = 4'd2,
    ST_T2   = 4'd3,
    ST_T3   = 4'd4,
    ST_T4   = 4'd5,
    ST_T5   = 4'd6,
    ST_T6   = 4'd7,
    ST_T7   = 4'd8,
    ST_HALT = 4'd9
  } state_t;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  state_t     state;
  logic       t1_first;
  logic [4:0] opcode;
  logic       is_reg, is_imm, is_ldi, is_ld, is_st, is_nop, is_halt, is_legal;
  logic       unused_bits;

  assign opcode      = instruction[31:27];
  assign unused_bits = ^instruction[26:0];

  assign is_reg   = (opcode == OP_ADD) || (opcode == OP_SUB) ||
                    (opcode == OP_AND) || (opcode == OP_OR);
  assign is_imm   = (opcode == OP_ADDI) || (opcode == OP_ANDI) || (opcode == OP_ORI);
  assign is_ldi   = (opcode == OP_LDI);
  assign is_ld    = (opcode == OP_LD);
  assign is_st    = (opcode == OP_ST);
  assign is_nop   = (opcode == OP_NOP);
  assign is_halt  = (opcode == OP_HALT);
  assign is_legal = is_reg || is_imm || is_ldi || is_ld || is_st || is_nop || is_halt;

  // t1_first marks the entry cycle of T1 so PCin fires once per fetch
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_RST;
      t1_first <= 1'b0;
    end else begin
      t1_first <= (state == ST_T0);
      case (state)
        ST_RST: state <= ST_T0;
        ST_T0:  state <= ST_T1;
        ST_T1:  if (mem_done) state <= ST_T2;
        ST_T2:  state <= ST_T3;
        ST_T3: begin
          if (is_halt)
            state <= ST_HALT;
          else if (is_reg || is_imm || is_ldi || is_ld || is_st)
            state <= ST_T4;
          else
            state <= ST_T0;
        end
        ST_T4:  state <= ST_T5;
        ST_T5:  state <= (is_ld || is_st) ? ST_T6 : ST_T0;
        ST_T6: begin
          if (!is_ld || mem_done) state <= ST_T7;
        end
        ST_T7: begin
          if (!is_st || mem_done) state <= ST_T0;
        end
        ST_HALT: state <= ST_HALT;
        default: state <= ST_RST;
      endcase
    end
  end

  always_comb begin
    Gra = 1'b0; Grb = 1'b0; Grc = 1'b0;
    Rin = 1'b0; Rout = 1'b0; BAout = 1'b0;
    PCout = 1'b0; PCin = 1'b0; IncPC = 1'b0; MARin = 1'b0;
    MDRin = 1'b0; MDRout = 1'b0; IRin = 1'b0; Yin = 1'b0;
    Zin = 1'b0; Zlowout = 1'b0; Cout = 1'b0;
    Read = 1'b0; Write = 1'b0;
    alu_op = 5'b00000;
    illegal_op = 1'b0;
    run = (state != ST_RST) && (state != ST_HALT);
    case (state)
      ST_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; end
      ST_T1: begin Zlowout = 1'b1; PCin = t1_first; Read = 1'b1; MDRin = 1'b1; end
      ST_T2: begin MDRout = 1'b1; IRin = 1'b1; end
      ST_T3: begin
        if (is_reg || is_imm) begin
          Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
        end else if (is_ldi || is_ld || is_st) begin
          Grb = 1'b1; BAout = 1'b1; Yin = 1'b1;
        end else if (!is_legal) begin
          illegal_op = 1'b1;
        end
      end
      ST_T4: begin
        if (is_reg) begin
          Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = opcode;
        end else if (is_imm || is_ldi || is_ld || is_st) begin
          Cout = 1'b1; Zin = 1'b1;
          case (opcode)
            OP_ANDI: alu_op = OP_AND;
            OP_ORI:  alu_op = OP_OR;
            default: alu_op = OP_ADD;
          endcase
        end
      end
      ST_T5: begin
        Zlowout = 1'b1;
        if (is_ld || is_st) MARin = 1'b1;
        else begin Gra = 1'b1; Rin = 1'b1; end
      end
      ST_T6: begin
        MDRin = 1'b1;
        if (is_st) begin Gra = 1'b1; Rout = 1'b1; end
        else Read = 1'b1;
      end
      ST_T7: begin
        MDRout = 1'b1;
        if (is_st) Write = 1'b1;
        else begin Gra = 1'b1; Rin = 1'b1; end
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_control_sequencer.sv
`default_nettype none
// ============================================================================
// tb_control_sequencer : table-driven per-cycle strobe checks plus reset/halt
// Rev 1.0
// ============================================================================
module tb_control_sequencer;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] instruction = 32'd0;
  logic        mem_done = 1'b0;
  logic Gra, Grb, Grc, Rin, Rout, BAout, PCout, PCin, IncPC, MARin;
  logic MDRin, MDRout, IRin, Yin, Zin, Zlowout, Cout, Read, Write, run, illegal_op;
  logic [4:0] alu_op;
  logic [25:0] obs;

  control_sequencer dut (
    .clock(clock), .reset_n(reset_n), .instruction(instruction), .mem_done(mem_done),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
    .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .MDRin(MDRin),
    .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .Zin(Zin), .Zlowout(Zlowout),
    .Cout(Cout), .Read(Read), .Write(Write), .alu_op(alu_op), .run(run),
    .illegal_op(illegal_op)
  );

  always #5 clock = ~clock;

  assign obs = {alu_op, Gra, Grb, Grc, Rin, Rout, BAout, PCout, PCin, IncPC, MARin,
                MDRin, MDRout, IRin, Yin, Zin, Zlowout, Cout, Read, Write, run, illegal_op};

  localparam logic [25:0] ILL = 26'h1 << 0,  RUN = 26'h1 << 1,  WR  = 26'h1 << 2;
  localparam logic [25:0] RD  = 26'h1 << 3,  CO  = 26'h1 << 4,  ZLO = 26'h1 << 5;
  localparam logic [25:0] ZI  = 26'h1 << 6,  YI  = 26'h1 << 7,  IRI = 26'h1 << 8;
  localparam logic [25:0] MDO = 26'h1 << 9,  MDI = 26'h1 << 10, MAI = 26'h1 << 11;
  localparam logic [25:0] INC = 26'h1 << 12, PCI = 26'h1 << 13, PCO = 26'h1 << 14;
  localparam logic [25:0] BAO = 26'h1 << 15, RO  = 26'h1 << 16, RI  = 26'h1 << 17;
  localparam logic [25:0] GRC = 26'h1 << 18, GRB = 26'h1 << 19, GRA = 26'h1 << 20;

  localparam logic [25:0] E_T0  = PCO | MAI | INC | ZI | RUN;
  localparam logic [25:0] E_T1F = ZLO | PCI | RD | MDI | RUN;
  localparam logic [25:0] E_T1W = ZLO | RD | MDI | RUN;
  localparam logic [25:0] E_T2  = MDO | IRI | RUN;
  localparam logic [25:0] E_R3  = GRB | RO | YI | RUN;
  localparam logic [25:0] E_B3  = GRB | BAO | YI | RUN;
  localparam logic [25:0] E_W5  = ZLO | GRA | RI | RUN;
  localparam logic [25:0] E_M5  = ZLO | MAI | RUN;
  localparam logic [25:0] E_L6  = RD | MDI | RUN;
  localparam logic [25:0] E_L7  = MDO | GRA | RI | RUN;
  localparam logic [25:0] E_S6  = GRA | RO | MDI | RUN;
  localparam logic [25:0] E_S7  = WR | MDO | RUN;

  localparam logic [31:0] I_ADD  = 32'h19888000;
  localparam logic [31:0] I_LD   = 32'h01080045;
  localparam logic [31:0] I_ST   = 32'h1200001F;
  localparam logic [31:0] I_HALT = 32'hD8000000;
  localparam logic [31:0] I_SUB  = {5'b00100, 27'h0123456};
  localparam logic [31:0] I_ANDI = {5'b01101, 27'h0000ABC};
  localparam logic [31:0] I_ORI  = {5'b01110, 27'h7FFFFFF};
  localparam logic [31:0] I_LDI  = {5'b00001, 27'h0000010};
  localparam logic [31:0] I_NOP  = {5'b11010, 27'h0};
  localparam logic [31:0] I_BAD  = {5'b11111, 27'h0};

  function automatic logic [25:0] alu(input logic [4:0] op);
    return {op, 21'b0};
  endfunction

  typedef struct {
    logic [31:0] instr;
    logic        md;
    logic [25:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;

  task automatic row(input logic [31:0] i, input logic md, input logic [25:0] e, input string n);
    vec_t v;
    v.instr = i; v.md = md; v.exp = e; v.name = n;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [25:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, obs, exp);
    end
  endtask

  task automatic chk_excl(input string name);
    checks++;
    if ((int'(Gra) + int'(Grb) + int'(Grc)) > 1 || (Rout && BAout)) begin
      errors++;
      $display("FAIL %s: exclusivity got Gr=%b%b%b Rout=%b BAout=%b expected at most one",
               name, Gra, Grb, Grc, Rout, BAout);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    // V1 add with mem_done tied high, then other ALU/immediate forms
    row(I_ADD, 1'b1, 26'h0, "rst_state");
    row(I_ADD, 1'b1, E_T0, "add_t0");  row(I_ADD, 1'b1, E_T1F, "add_t1");
    row(I_ADD, 1'b1, E_T2, "add_t2");  row(I_ADD, 1'b1, E_R3, "add_t3");
    row(I_ADD, 1'b1, GRC | RO | ZI | RUN | alu(5'b00011), "add_t4");
    row(I_ADD, 1'b1, E_W5, "add_t5");
    row(I_SUB, 1'b1, E_T0, "sub_t0");  row(I_SUB, 1'b1, E_T1F, "sub_t1");
    row(I_SUB, 1'b1, E_T2, "sub_t2");  row(I_SUB, 1'b1, E_R3, "sub_t3");
    row(I_SUB, 1'b1, GRC | RO | ZI | RUN | alu(5'b00100), "sub_t4");
    row(I_SUB, 1'b1, E_W5, "sub_t5");
    row(I_ANDI, 1'b0, E_T0, "andi_t0"); row(I_ANDI, 1'b1, E_T1F, "andi_t1");
    row(I_ANDI, 1'b0, E_T2, "andi_t2"); row(I_ANDI, 1'b0, E_R3, "andi_t3");
    row(I_ANDI, 1'b0, CO | ZI | RUN | alu(5'b00101), "andi_t4");
    row(I_ANDI, 1'b0, E_W5, "andi_t5");
    row(I_LDI, 1'b1, E_T0, "ldi_t0");  row(I_LDI, 1'b1, E_T1F, "ldi_t1");
    row(I_LDI, 1'b1, E_T2, "ldi_t2");  row(I_LDI, 1'b1, E_B3, "ldi_t3");
    row(I_LDI, 1'b1, CO | ZI | RUN | alu(5'b00011), "ldi_t4");
    row(I_LDI, 1'b1, E_W5, "ldi_t5");
    // V2 ld with 3-cycle T1 and 2-cycle T6
    row(I_LD, 1'b0, E_T0, "ld_t0");    row(I_LD, 1'b0, E_T1F, "ld_t1a");
    row(I_LD, 1'b0, E_T1W, "ld_t1b");  row(I_LD, 1'b1, E_T1W, "ld_t1c");
    row(I_LD, 1'b0, E_T2, "ld_t2");    row(I_LD, 1'b1, E_B3, "ld_t3");
    row(I_LD, 1'b1, CO | ZI | RUN | alu(5'b00011), "ld_t4");
    row(I_LD, 1'b1, E_M5, "ld_t5");    row(I_LD, 1'b0, E_L6, "ld_t6a");
    row(I_LD, 1'b1, E_L6, "ld_t6b");   row(I_LD, 1'b0, E_L7, "ld_t7");
    // V3 st: T6 ignores mem_done, T7 holds Write until mem_done
    row(I_ST, 1'b1, E_T0, "st_t0");    row(I_ST, 1'b1, E_T1F, "st_t1");
    row(I_ST, 1'b1, E_T2, "st_t2");    row(I_ST, 1'b1, E_B3, "st_t3");
    row(I_ST, 1'b1, CO | ZI | RUN | alu(5'b00011), "st_t4");
    row(I_ST, 1'b1, E_M5, "st_t5");    row(I_ST, 1'b0, E_S6, "st_t6");
    row(I_ST, 1'b0, E_S7, "st_t7a");   row(I_ST, 1'b0, E_S7, "st_t7b");
    row(I_ST, 1'b1, E_S7, "st_t7c");
    // V5 undefined opcode, then nop and ori
    row(I_BAD, 1'b1, E_T0, "bad_t0");  row(I_BAD, 1'b1, E_T1F, "bad_t1");
    row(I_BAD, 1'b1, E_T2, "bad_t2");  row(I_BAD, 1'b1, ILL | RUN, "bad_t3");
    row(I_NOP, 1'b1, E_T0, "nop_t0");  row(I_NOP, 1'b1, E_T1F, "nop_t1");
    row(I_NOP, 1'b1, E_T2, "nop_t2");  row(I_NOP, 1'b1, RUN, "nop_t3");
    row(I_ORI, 1'b1, E_T0, "ori_t0");  row(I_ORI, 1'b1, E_T1F, "ori_t1");
    row(I_ORI, 1'b1, E_T2, "ori_t2");  row(I_ORI, 1'b1, E_R3, "ori_t3");
    row(I_ORI, 1'b1, CO | ZI | RUN | alu(5'b00110), "ori_t4");
    row(I_ORI, 1'b1, E_W5, "ori_t5");

    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("in_reset", 26'h0);
    reset_n = 1'b1;

    foreach (vecs[k]) begin
      instruction = vecs[k].instr;
      mem_done    = vecs[k].md;
      @(negedge clock);
      chk(vecs[k].name, vecs[k].exp);
      chk_excl(vecs[k].name);
      step();
    end

    // V6: ld interrupted by reset in the T6 wait
    instruction = I_LD;
    mem_done    = 1'b1;
    @(negedge clock);
    chk("v6_t0", E_T0);
    repeat (6) step();
    mem_done = 1'b0;
    @(negedge clock);
    chk("v6_t6", E_L6);
    #1 reset_n = 1'b0;
    #1 chk("v6_async_clear", 26'h0);
    step();
    chk("v6_held_low", 26'h0);
    reset_n = 1'b1;
    @(negedge clock);
    chk("v6_rst", 26'h0);
    step();
    @(negedge clock);
    chk("v6_t0_after", E_T0);

    // V4: halt is absorbing while mem_done toggles
    instruction = I_HALT;
    mem_done    = 1'b1;
    step();
    @(negedge clock); chk("halt_t1", E_T1F);
    step();
    @(negedge clock); chk("halt_t2", E_T2);
    step();
    @(negedge clock); chk("halt_t3", RUN);
    for (int c = 0; c < 20; c++) begin
      step();
      mem_done = c[0];
      @(negedge clock);
      chk($sformatf("halt_c%0d", c), 26'h0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got no finish expected finish before 20000");
    $fatal(1);
  end

endmodule
`default_nettype wire
